// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two cache clients (0 = I-side, 1 = D-side) onto a
// single-outstanding memory port, with round-robin tie breaking, a BUSY
// timeout that lands in a sticky ERROR state, and registered outputs.
// Build macro ARB_FIXED_PRIO_EN: simultaneous requests always go to client 1.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        c0_read,
    input  logic        c0_write,
    input  logic [31:0] c0_address,
    input  logic [31:0] c0_wdata,
    output logic        c0_write_back,
    output logic        c0_read_allocate,
    output logic [31:0] c0_rdata,
    input  logic        c1_read,
    input  logic        c1_write,
    input  logic [31:0] c1_address,
    input  logic [31:0] c1_wdata,
    output logic        c1_write_back,
    output logic        c1_read_allocate,
    output logic [31:0] c1_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Counter value seen in the last BUSY cycle allowed before timing out
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  timeout_cnt, timeout_cnt_next;
    logic        mem_req_next, mem_we_next, err_next, owner_next;
    logic [31:0] mem_addr_next, mem_wdata_next;
    logic [31:0] c0_rdata_next, c1_rdata_next;
    logic        c0_write_back_next, c0_read_allocate_next;
    logic        c1_write_back_next, c1_read_allocate_next;
    logic        c0_pending, c1_pending, tie_grant, grant;

    assign c0_pending = c0_read | c0_write;
    assign c1_pending = c1_read | c1_write;

`ifdef ARB_FIXED_PRIO_EN
    assign tie_grant = 1'b1;
`else
    logic last_grant;
    assign tie_grant = ~last_grant;

    // Remember who completed last so the next tie goes to the other client
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            last_grant <= 1'b1;
        end else if (state == DONE) begin
            last_grant <= owner;
        end
    end
`endif

    assign grant = (c0_pending && c1_pending) ? tie_grant : c1_pending;

    // Next-state and next-output computation; every output is registered below
    always_comb begin
        state_next            = state;
        timeout_cnt_next      = timeout_cnt;
        mem_req_next          = mem_req;
        mem_we_next           = mem_we;
        mem_addr_next         = mem_addr;
        mem_wdata_next        = mem_wdata;
        err_next              = err;
        owner_next            = owner;
        c0_rdata_next         = c0_rdata;
        c1_rdata_next         = c1_rdata;
        c0_write_back_next    = 1'b0;
        c0_read_allocate_next = 1'b0;
        c1_write_back_next    = 1'b0;
        c1_read_allocate_next = 1'b0;

        case (state)
            IDLE: begin
                if (c0_pending || c1_pending) begin
                    owner_next       = grant;
                    mem_we_next      = grant ? c1_write : c0_write;
                    mem_addr_next    = grant ? c1_address : c0_address;
                    mem_wdata_next   = grant ? c1_wdata : c0_wdata;
                    mem_req_next     = 1'b1;
                    timeout_cnt_next = 8'd0;
                    state_next       = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_next          = 1'b0;
                    state_next            = DONE;
                    c0_write_back_next    = ~owner & mem_we;
                    c0_read_allocate_next = ~owner & ~mem_we;
                    c1_write_back_next    = owner & mem_we;
                    c1_read_allocate_next = owner & ~mem_we;
                    if (!mem_we) begin
                        if (owner) begin
                            c1_rdata_next = mem_rdata;
                        end else begin
                            c0_rdata_next = mem_rdata;
                        end
                    end
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    mem_req_next = 1'b0;
                    err_next     = 1'b1;
                    state_next   = ERROR;
                end else begin
                    timeout_cnt_next = timeout_cnt + 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by areset
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state            <= IDLE;
            timeout_cnt      <= 8'd0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= 32'd0;
            mem_wdata        <= 32'd0;
            err              <= 1'b0;
            owner            <= 1'b0;
            c0_rdata         <= 32'd0;
            c1_rdata         <= 32'd0;
            c0_write_back    <= 1'b0;
            c0_read_allocate <= 1'b0;
            c1_write_back    <= 1'b0;
            c1_read_allocate <= 1'b0;
        end else begin
            state            <= state_next;
            timeout_cnt      <= timeout_cnt_next;
            mem_req          <= mem_req_next;
            mem_we           <= mem_we_next;
            mem_addr         <= mem_addr_next;
            mem_wdata        <= mem_wdata_next;
            err              <= err_next;
            owner            <= owner_next;
            c0_rdata         <= c0_rdata_next;
            c1_rdata         <= c1_rdata_next;
            c0_write_back    <= c0_write_back_next;
            c0_read_allocate <= c0_read_allocate_next;
            c1_write_back    <= c1_write_back_next;
            c1_read_allocate <= c1_read_allocate_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and randomized checking of mem_arbiter with a
// transaction-level reference model; TIMEOUT is shortened to 4.
module tb_mem_arbiter;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        areset;
    logic        c0_read, c0_write, c1_read, c1_write;
    logic [31:0] c0_address, c0_wdata, c1_address, c1_wdata;
    logic        c0_write_back, c0_read_allocate, c1_write_back, c1_read_allocate;
    logic [31:0] c0_rdata, c1_rdata;
    logic        mem_req, mem_we, mem_ack, err, owner;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  pulses;

    int checks = 0;
    int errors = 0;

    logic        model_last;
    logic [31:0] model_rd [2];

    typedef struct {
        logic        c0r, c0w, c1r, c1w;
        logic [31:0] a0, w0, a1, w1;
        int          k;
        logic [31:0] rd;
        logic        drop;
        logic        eowner, ewe;
        logic [31:0] eaddr, ewdata, erd0, erd1;
        logic        eerr;
    } vec_t;

    vec_t tbl [6];

    assign pulses = {c0_write_back, c0_read_allocate, c1_write_back, c1_read_allocate};

    mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .areset(areset),
        .c0_read(c0_read), .c0_write(c0_write), .c0_address(c0_address), .c0_wdata(c0_wdata),
        .c0_write_back(c0_write_back), .c0_read_allocate(c0_read_allocate), .c0_rdata(c0_rdata),
        .c1_read(c1_read), .c1_write(c1_write), .c1_address(c1_address), .c1_wdata(c1_wdata),
        .c1_write_back(c1_write_back), .c1_read_allocate(c1_read_allocate), .c1_rdata(c1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .owner(owner)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] ad0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [31:0] ad1, input logic [31:0] d1);
        c0_read = r0; c0_write = w0; c0_address = ad0; c0_wdata = d0;
        c1_read = r1; c1_write = w1; c1_address = ad1; c1_wdata = d1;
    endtask

    task automatic clearRequests();
        c0_read = 1'b0; c0_write = 1'b0; c1_read = 1'b0; c1_write = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mem_req"}, mem_req, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_pulses"}, pulses, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_c0_rdata"}, c0_rdata, 0);
        checkOutput({tag, "_c1_rdata"}, c1_rdata, 0);
        checkOutput({tag, "_owner"}, owner, 0);
    endtask

    task automatic doReset(input string tag);
        clearRequests();
        mem_ack = 1'b0;
        areset = 1'b1;
        #2;
        checkResetValues(tag);
        step();
        areset = 1'b0;
        model_last = 1'b1;
        model_rd[0] = 32'd0;
        model_rd[1] = 32'd0;
    endtask

    function automatic vec_t mkVec(input logic c0r, input logic c0w, input logic [31:0] a0, input logic [31:0] w0,
                                   input logic c1r, input logic c1w, input logic [31:0] a1, input logic [31:0] w1,
                                   input int k, input logic [31:0] rd, input logic drop,
                                   input logic eowner, input logic ewe, input logic [31:0] eaddr,
                                   input logic [31:0] ewdata, input logic [31:0] erd0, input logic [31:0] erd1,
                                   input logic eerr);
        vec_t v;
        v.c0r = c0r; v.c0w = c0w; v.a0 = a0; v.w0 = w0;
        v.c1r = c1r; v.c1w = c1w; v.a1 = a1; v.w1 = w1;
        v.k = k; v.rd = rd; v.drop = drop;
        v.eowner = eowner; v.ewe = ewe; v.eaddr = eaddr; v.ewdata = ewdata;
        v.erd0 = erd0; v.erd1 = erd1; v.eerr = eerr;
        return v;
    endfunction

    // Reference model: who wins, what goes out, and what each client's read data becomes
    function automatic vec_t predict(input vec_t v);
        vec_t   r;
        logic   p0, p1, g;
        r  = v;
        p0 = v.c0r | v.c0w;
        p1 = v.c1r | v.c1w;
        if (p0 && p1) begin
`ifdef ARB_FIXED_PRIO_EN
            g = 1'b1;
`else
            g = ~model_last;
`endif
        end else begin
            g = p1;
        end
        r.eowner = g;
        r.ewe    = g ? v.c1w : v.c0w;
        r.eaddr  = g ? v.a1 : v.a0;
        r.ewdata = g ? v.w1 : v.w0;
        r.eerr   = (v.k > TB_TIMEOUT);
        r.erd0   = model_rd[0];
        r.erd1   = model_rd[1];
        if (!r.eerr && !r.ewe) begin
            if (g) r.erd1 = v.rd;
            else   r.erd0 = v.rd;
        end
        return r;
    endfunction

    // One complete transaction from an idle arbiter: grant, BUSY hold, ack or timeout, done pulse
    task automatic runTxn(input vec_t v);
        int busy_cycles;
        bit finished;
        logic [3:0] exp_pulses;
        applyStimulus(v.c0r, v.c0w, v.a0, v.w0, v.c1r, v.c1w, v.a1, v.w1);
        step();
        checkOutput("grant_owner", owner, v.eowner);
        checkOutput("busy_mem_we", mem_we, v.ewe);
        checkOutput("busy_mem_addr", mem_addr, v.eaddr);
        checkOutput("busy_mem_wdata", mem_wdata, v.ewdata);
        busy_cycles = 0;
        finished = 0;
        for (int cyc = 1; cyc <= TB_TIMEOUT + 2 && !finished; cyc++) begin
            if (mem_req) busy_cycles++;
            if (v.drop && cyc == 1) clearRequests();
            if (cyc == v.k) begin
                mem_ack = 1'b1;
                mem_rdata = v.rd;
                step();
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                finished = 1;
            end else if (cyc == TB_TIMEOUT) begin
                step();
                finished = 1;
            end else begin
                step();
            end
        end
        clearRequests();
        checkOutput("mem_req_cycles", busy_cycles, v.eerr ? TB_TIMEOUT : v.k);
        if (!v.eerr) begin
            exp_pulses = {~v.eowner & v.ewe, ~v.eowner & ~v.ewe, v.eowner & v.ewe, v.eowner & ~v.ewe};
            checkOutput("done_mem_req", mem_req, 0);
            checkOutput("done_pulses", pulses, exp_pulses);
            checkOutput("done_c0_rdata", c0_rdata, v.erd0);
            checkOutput("done_c1_rdata", c1_rdata, v.erd1);
            checkOutput("done_err", err, 0);
            step();
            checkOutput("idle_pulses", pulses, 0);
            checkOutput("idle_mem_req", mem_req, 0);
            model_last  = v.eowner;
            model_rd[0] = v.erd0;
            model_rd[1] = v.erd1;
        end else begin
            checkOutput("timeout_err", err, 1);
            checkOutput("timeout_mem_req", mem_req, 0);
            checkOutput("timeout_pulses", pulses, 0);
            c0_read = 1'b1;
            c1_write = 1'b1;
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            step();
            checkOutput("error_sticky_err", err, 1);
            checkOutput("error_no_req", mem_req, 0);
            checkOutput("error_no_pulse", pulses, 0);
            doReset("err_clear");
        end
    endtask

    initial begin
        logic exp_order [3];
        vec_t v;
        int waited;

        areset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        doReset("reset");

        // Directed vectors; state carries from one entry to the next
        tbl[0] = mkVec(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 3, 32'hDEADBEEF, 0,
                       0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 32'h0, 0);
        tbl[1] = mkVec(0, 0, 32'h0, 32'h0, 0, 1, 32'h7F, 32'h12345678, 2, 32'hBAD0BAD0, 0,
                       1, 1, 32'h7F, 32'h12345678, 32'hDEADBEEF, 32'h0, 0);
        tbl[2] = mkVec(1, 1, 32'h100, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0, 1, 32'h55555555, 1,
                       0, 1, 32'h100, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0, 0);
        tbl[3] = mkVec(0, 0, 32'h0, 32'h0, 1, 0, 32'hFFFFFFFF, 32'h0, TB_TIMEOUT, 32'h0BADF00D, 0,
                       1, 0, 32'hFFFFFFFF, 32'h0, 32'hDEADBEEF, 32'h0BADF00D, 0);
        tbl[4] = mkVec(1, 0, 32'h44, 32'h0, 0, 0, 32'h0, 32'h0, TB_TIMEOUT + 1, 32'h0, 0,
                       0, 0, 32'h44, 32'h0, 32'hDEADBEEF, 32'h0BADF00D, 1);
        tbl[5] = mkVec(0, 0, 32'h0, 32'h0, 1, 0, 32'h80, 32'h0, 1, 32'h11111111, 1,
                       1, 0, 32'h80, 32'h0, 32'h0, 32'h11111111, 0);
        for (int i = 0; i < 6; i++) begin
            runTxn(tbl[i]);
        end

        // Both clients hold requests across three back-to-back transactions
`ifdef ARB_FIXED_PRIO_EN
        exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
`else
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
`endif
        doReset("rr_reset");
        applyStimulus(1, 0, 32'h100, 32'h0, 1, 0, 32'h200, 32'h0);
        for (int t = 0; t < 3; t++) begin
            waited = 0;
            while (!mem_req && waited < 4) begin
                step();
                waited++;
            end
            checkOutput("rr_req_seen", mem_req, 1);
            checkOutput("rr_owner", owner, exp_order[t]);
            checkOutput("rr_addr", mem_addr, exp_order[t] ? 32'h200 : 32'h100);
            mem_ack = 1'b1;
            mem_rdata = 32'hC0DE0000 + 32'(t);
            step();
            mem_ack = 1'b0;
            checkOutput("rr_pulse", pulses, exp_order[t] ? 4'b0001 : 4'b0100);
            step();
            checkOutput("rr_done_ignores_req", mem_req, 0);
        end
        clearRequests();
        step();

        // Reset in the middle of BUSY, then a stray ack
        doReset("mid_reset_pre");
        applyStimulus(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
        step();
        checkOutput("mid_busy_req", mem_req, 1);
        step();
        areset = 1'b1;
        #2;
        checkResetValues("mid_busy_reset");
        step();
        areset = 1'b0;
        clearRequests();
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("post_reset_pulses", pulses, 0);
            checkOutput("post_reset_mem_req", mem_req, 0);
            checkOutput("post_reset_c0_rdata", c0_rdata, 0);
            step();
        end
        model_last = 1'b1;
        model_rd[0] = 32'd0;
        model_rd[1] = 32'd0;

        // Randomized transactions against the reference model
        for (int t = 0; t < 60; t++) begin
            do begin
                v.c0r = 1'($urandom); v.c0w = 1'($urandom);
                v.c1r = 1'($urandom); v.c1w = 1'($urandom);
            end while (!(v.c0r | v.c0w | v.c1r | v.c1w));
            v.a0 = $urandom; v.w0 = $urandom; v.a1 = $urandom; v.w1 = $urandom;
            v.k = int'($urandom_range(1, TB_TIMEOUT + 2));
            v.rd = $urandom;
            v.drop = 1'($urandom);
            v = predict(v);
            runTxn(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
